// File: rtl/sfft_pkg.sv
// Shared definitions for the second-FFT bin selection path.
// Holds the default beat geometry, the beat record and the selector state type.
package sfft_pkg;

  localparam int unsigned SFFT_DATA_W  = 80;
  localparam int unsigned SFFT_IDX_W   = 7;
  localparam int unsigned SFFT_K_W     = 4;
  localparam int unsigned SFFT_N_SEL   = 8;
  localparam int unsigned SFFT_FIFO_AW = 4;

  // One FFT output beat.
  typedef struct packed {
    logic [SFFT_DATA_W-1:0] data;
    logic [SFFT_IDX_W-1:0]  index;
    logic [SFFT_K_W-1:0]    k;
  } beat_t;

  // EMPTY: no selection active, beats are discarded.
  // RUN:   beats whose k matches the current ring entry are kept.
  typedef enum logic {
    SEL_EMPTY = 1'b0,
    SEL_RUN   = 1'b1
  } sel_state_e;

endpackage

// File: rtl/sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   wr_en, wr_data    push request and data (ignored while full)
//   rd_en             pop request (ignored while empty)
//   rd_data           head of queue, zero while empty
//   full, empty       registered status flags
// A word pushed at one edge is visible on rd_data right after that edge.
module sync_fifo_fwft #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AW    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic [AW:0]      count_next;
  logic             do_wr;
  logic             do_rd;

  assign do_wr = wr_en & ~full;
  assign do_rd = rd_en & ~empty;

  always_comb begin
    count_next = count;
    case ({do_wr, do_rd})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  // Flags are registered from the next count, so a pop in the same cycle
  // as a full condition only reopens the write side on the following cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
      full  <= (count_next == (AW+1)'(DEPTH));
      empty <= (count_next == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  // Head is forced to zero while empty so the outputs read clean after reset.
  assign rd_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/sfft_bin_selector.sv
// Sink for the second-FFT output stream. Every beat is consumed; only beats
// whose bin number matches the current entry of a host-loaded selection ring
// are queued to the downstream stream. The ring advances once per frame.
// Ports:
//   clk, rst_n                        clock, asynchronous active-low reset
//   s_data/s_index/s_k/s_valid/s_last input beat stream, s_ready = FIFO not full
//   cfg_wr_en, cfg_k                  append a k value to the ring
//   cfg_clear                         empty the ring and rewind its pointer
//   cfg_err                           sticky: append attempted on a full ring
//   ring_count                        number of loaded ring entries
//   m_data/m_index/m_k/m_valid/m_ready selected beat stream (FWFT)
//   frame_cnt                         accepted frames, wraps at 2^16
module sfft_bin_selector
  import sfft_pkg::*;
#(
  parameter int unsigned DATA_W  = SFFT_DATA_W,
  parameter int unsigned IDX_W   = SFFT_IDX_W,
  parameter int unsigned K_W     = SFFT_K_W,
  parameter int unsigned N_SEL   = SFFT_N_SEL,
  parameter int unsigned FIFO_AW = SFFT_FIFO_AW
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DATA_W-1:0]       s_data,
  input  logic [IDX_W-1:0]        s_index,
  input  logic [K_W-1:0]          s_k,
  input  logic                    s_valid,
  input  logic                    s_last,
  output logic                    s_ready,
  input  logic                    cfg_wr_en,
  input  logic [K_W-1:0]          cfg_k,
  input  logic                    cfg_clear,
  output logic                    cfg_err,
  output logic [$clog2(N_SEL):0]  ring_count,
  output logic [DATA_W-1:0]       m_data,
  output logic [IDX_W-1:0]        m_index,
  output logic [K_W-1:0]          m_k,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [15:0]             frame_cnt
);

  localparam int unsigned PTR_W  = $clog2(N_SEL);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned BEAT_W = DATA_W + IDX_W + K_W;

  sel_state_e       state;
  sel_state_e       state_next;
  logic [K_W-1:0]   ring [N_SEL];
  logic [PTR_W-1:0] rd_ptr;
  logic             in_frame;
  logic             in_frame_next;
  logic             accept;
  logic             ring_full;
  logic             ptr_at_end;
  logic [K_W-1:0]   sel_k;
  logic             fifo_wr;
  logic             fifo_full;
  logic             fifo_empty;
  logic [BEAT_W-1:0] fifo_din;
  logic [BEAT_W-1:0] fifo_dout;

  assign s_ready       = ~fifo_full;
  assign accept        = s_valid & s_ready;
  assign sel_k         = ring[rd_ptr];
  assign ring_full     = (ring_count == CNT_W'(N_SEL));
  assign ptr_at_end    = ({1'b0, rd_ptr} == ring_count - 1'b1);
  assign in_frame_next = accept ? ~s_last : in_frame;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= SEL_EMPTY;
    else        state <= state_next;
  end

  // Next state. Entering RUN waits until the current beat leaves us between
  // frames, so a selection never starts on a partial frame.
  always_comb begin
    state_next = state;
    case (state)
      SEL_EMPTY: if (!cfg_clear && ring_count != '0 && !in_frame_next) state_next = SEL_RUN;
      SEL_RUN:   if (cfg_clear) state_next = SEL_EMPTY;
      default:   state_next = SEL_EMPTY;
    endcase
  end

  // Output decode. The beat seen in a cfg_clear cycle is already discarded.
  always_comb begin
    fifo_wr = 1'b0;
    if (state == SEL_RUN && !cfg_clear && accept && s_k == sel_k) fifo_wr = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_frame  <= 1'b0;
      frame_cnt <= '0;
    end else begin
      in_frame <= in_frame_next;
      if (accept && s_last) frame_cnt <= frame_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
    end else if (cfg_clear) begin
      rd_ptr <= '0;
    end else if (state == SEL_RUN && accept && s_last) begin
      rd_ptr <= ptr_at_end ? '0 : rd_ptr + 1'b1;
    end
  end

  // Ring load: clear wins over append; append to a full ring only flags an error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < N_SEL; i++) ring[i] <= '0;
      ring_count <= '0;
      cfg_err    <= 1'b0;
    end else if (cfg_clear) begin
      ring_count <= '0;
      cfg_err    <= 1'b0;
    end else if (cfg_wr_en) begin
      if (ring_full) begin
        cfg_err <= 1'b1;
      end else begin
        ring[ring_count[PTR_W-1:0]] <= cfg_k;
        ring_count <= ring_count + 1'b1;
      end
    end
  end

  assign fifo_din = {s_data, s_index, s_k};

  sync_fifo_fwft #(
    .WIDTH (BEAT_W),
    .AW    (FIFO_AW)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (fifo_wr),
    .wr_data (fifo_din),
    .rd_en   (m_ready),
    .rd_data (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign m_valid = ~fifo_empty;
  assign {m_data, m_index, m_k} = fifo_dout;

endmodule

// File: tb/tb_sfft_bin_selector.sv
module tb_sfft_bin_selector;
  import sfft_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [79:0] s_data;
  logic [6:0]  s_index;
  logic [3:0]  s_k;
  logic        s_valid;
  logic        s_last;
  logic        s_ready;
  logic        cfg_wr_en;
  logic [3:0]  cfg_k;
  logic        cfg_clear;
  logic        cfg_err;
  logic [3:0]  ring_count;
  logic [79:0] m_data;
  logic [6:0]  m_index;
  logic [3:0]  m_k;
  logic        m_valid;
  logic        m_ready;
  logic [15:0] frame_cnt;

  sfft_bin_selector dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_data     (s_data),
    .s_index    (s_index),
    .s_k        (s_k),
    .s_valid    (s_valid),
    .s_last     (s_last),
    .s_ready    (s_ready),
    .cfg_wr_en  (cfg_wr_en),
    .cfg_k      (cfg_k),
    .cfg_clear  (cfg_clear),
    .cfg_err    (cfg_err),
    .ring_count (ring_count),
    .m_data     (m_data),
    .m_index    (m_index),
    .m_k        (m_k),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .frame_cnt  (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a list of selected k values, a queue of expected output
  // beats, and a flag telling whether a selection is active.
  int    ring_q[$];
  beat_t exp_q[$];
  bit    m_active;
  int    m_rptr;
  bit    m_inframe;
  int    m_frames;
  bit    m_err;
  int    pushes;

  // Stimulus state
  int unsigned valid_pct;
  int unsigned ready_pct;
  bit          rand_cfg;
  int          beat_pos;
  bit          acc_last;
  bit          nxt_wr;
  bit          nxt_clear;
  logic [3:0]  nxt_k;

  function automatic bit model_sready();
    return exp_q.size() < 16;
  endfunction

  task automatic model_reset();
    ring_q.delete();
    exp_q.delete();
    m_active  = 1'b0;
    m_rptr    = 0;
    m_inframe = 1'b0;
    m_frames  = 0;
    m_err     = 1'b0;
    beat_pos  = 0;
    acc_last  = 1'b1;
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    bit    acc;
    bit    push;
    bit    nif;
    beat_t b;
    acc  = s_valid && model_sready();
    push = 1'b0;
    if (m_active && !cfg_clear && acc && ring_q.size() > 0)
      push = (int'(s_k) == ring_q[m_rptr]);
    if (m_ready && exp_q.size() > 0) void'(exp_q.pop_front());
    if (push) begin
      b.data  = s_data;
      b.index = s_index;
      b.k     = s_k;
      exp_q.push_back(b);
      pushes++;
    end
    if (acc && s_last) m_frames = (m_frames + 1) % 65536;
    nif = acc ? !s_last : m_inframe;
    if (cfg_clear) m_rptr = 0;
    else if (m_active && acc && s_last) m_rptr = (m_rptr + 1) % ring_q.size();
    if (m_active) begin
      if (cfg_clear) m_active = 1'b0;
    end else if (!cfg_clear && ring_q.size() > 0 && !nif) begin
      m_active = 1'b1;
    end
    m_inframe = nif;
    if (cfg_clear) begin
      ring_q.delete();
      m_err = 1'b0;
    end else if (cfg_wr_en) begin
      if (ring_q.size() < 8) ring_q.push_back(int'(cfg_k));
      else m_err = 1'b1;
    end
    acc_last = acc;
    if (acc) beat_pos = (beat_pos + 1) % 16;
  endtask

  task automatic check_outputs();
    check("m_valid", m_valid, exp_q.size() > 0);
    if (exp_q.size() > 0) begin
      check("m_data", m_data, exp_q[0].data);
      check("m_index", m_index, exp_q[0].index);
      check("m_k", m_k, exp_q[0].k);
    end
    check("s_ready", s_ready, model_sready());
    check("frame_cnt", frame_cnt, m_frames);
    check("ring_count", ring_count, ring_q.size());
    check("cfg_err", cfg_err, m_err);
  endtask

  // One clock: check at the falling edge, drive the next inputs, step the model.
  task automatic cycle();
    logic [95:0] rnd;
    @(negedge clk);
    check_outputs();
    if (!(s_valid && !acc_last)) begin
      s_valid = ($urandom_range(0, 99) < valid_pct);
      s_k     = 4'(beat_pos);
      s_last  = (beat_pos == 15);
      rnd     = {$urandom(), $urandom(), $urandom()};
      s_data  = rnd[79:0];
      s_index = 7'($urandom());
    end
    m_ready = ($urandom_range(0, 99) < ready_pct);
    if (rand_cfg) begin
      if ($urandom_range(0, 199) == 0) nxt_clear = 1'b1;
      else if ($urandom_range(0, 29) == 0) begin
        nxt_wr = 1'b1;
        nxt_k  = 4'($urandom());
      end
    end
    cfg_wr_en = nxt_wr;
    cfg_k     = nxt_k;
    cfg_clear = nxt_clear;
    nxt_wr    = 1'b0;
    nxt_clear = 1'b0;
    model_step();
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  task automatic load_k(input int k);
    nxt_wr = 1'b1;
    nxt_k  = 4'(k);
    cycle();
  endtask

  task automatic clear_ring();
    nxt_clear = 1'b1;
    cycle();
  endtask

  int p0;
  int guard;

  initial begin
    rst_n = 1'b0;
    s_data = '0; s_index = '0; s_k = '0; s_valid = 1'b0; s_last = 1'b0;
    cfg_wr_en = 1'b0; cfg_k = '0; cfg_clear = 1'b0; m_ready = 1'b0;
    nxt_wr = 1'b0; nxt_clear = 1'b0; nxt_k = '0;
    valid_pct = 100; ready_pct = 100; rand_cfg = 1'b0; pushes = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_m_valid", m_valid, 1'b0);
    check("rst_s_ready", s_ready, 1'b1);
    check("rst_frame_cnt", frame_cnt, 0);
    check("rst_ring_count", ring_count, 0);
    check("rst_cfg_err", cfg_err, 1'b0);
    check("rst_m_data", {m_data, m_index, m_k}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Empty ring: everything discarded, frames still counted
    repeat (64) cycle();
    settle();
    check("nocfg_frames", frame_cnt, 4);
    check("nocfg_outputs", pushes, 0);
    check("nocfg_s_ready", s_ready, 1'b1);

    // Ring {3,5}, loaded mid-frame; that frame is skipped, then 4 frames
    p0 = pushes;
    load_k(3);
    load_k(5);
    repeat (78) cycle();
    settle();
    check("ring35_outputs", pushes - p0, 4);

    // Ring {7} with downstream stalled: FIFO fills, input back-pressured
    clear_ring();
    load_k(7);
    ready_pct = 0;
    repeat (400) cycle();
    settle();
    check("stall_s_ready", s_ready, 1'b0);
    check("stall_m_valid", m_valid, 1'b1);
    ready_pct = 100;
    repeat (120) cycle();

    // Ring overflow
    clear_ring();
    for (int i = 0; i < 9; i++) load_k(i);
    settle();
    check("ovf_cfg_err", cfg_err, 1'b1);
    check("ovf_ring_count", ring_count, 8);
    clear_ring();
    settle();
    check("clr_cfg_err", cfg_err, 1'b0);
    check("clr_ring_count", ring_count, 0);

    // cfg_clear at beat 5 of a selected frame, then reload
    load_k(5);
    guard = 0;
    while (!(beat_pos == 5 && m_active && m_inframe) && guard < 200) begin
      cycle();
      guard++;
    end
    check("beat5_reached", guard < 200, 1'b1);
    clear_ring();
    p0 = pushes;
    load_k(5);
    repeat (9) cycle();
    settle();
    check("midclr_outputs", pushes - p0, 0);
    repeat (16) cycle();
    settle();
    check("reload_outputs", pushes - p0, 1);

    // Random traffic and configuration
    valid_pct = 70;
    ready_pct = 60;
    rand_cfg  = 1'b1;
    repeat (3000) cycle();
    rand_cfg  = 1'b0;

    // Asynchronous reset mid-frame with a full FIFO
    valid_pct = 100;
    ready_pct = 100;
    clear_ring();
    load_k(7);
    ready_pct = 0;
    guard = 0;
    while (exp_q.size() < 16 && guard < 1000) begin
      cycle();
      guard++;
    end
    check("fill_reached", guard < 1000, 1'b1);
    repeat (3) cycle();
    @(negedge clk);
    check_outputs();
    #1;
    s_valid = 1'b0; cfg_wr_en = 1'b0; cfg_clear = 1'b0; m_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    check("arst_m_valid", m_valid, 1'b0);
    check("arst_s_ready", s_ready, 1'b1);
    check("arst_frame_cnt", frame_cnt, 0);
    check("arst_ring_count", ring_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    settle();
    check("post_rst_ring_count", ring_count, 0);
    check("post_rst_frame_cnt", frame_cnt, 0);
    repeat (40) cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
